// File: rtl/tx_serializer.sv
// Transmit serializer: shifts pre-encoded line symbols onto a 1-bit line, fills gaps with
// an idle comma, optionally forces periodic alignment commas, and can emit a PRBS instead.
module tx_serializer #(
    parameter int unsigned          SYM_W        = 10,
    parameter logic [SYM_W-1:0]     IDLE_SYM     = 10'h17C,
    parameter bit                   LSB_FIRST    = 1'b1,
    parameter int unsigned          ALIGN_PERIOD = 0,
    parameter int unsigned          PRBS_LEN     = 16,
    parameter logic [PRBS_LEN-1:0]  PRBS_TAPS    = 16'hB400,
    parameter logic [PRBS_LEN-1:0]  PRBS_SEED    = 16'h5678
) (
    input  logic             clk_bit,
    input  logic             rst,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic             prbs_on,
    output logic             out,
    output logic             idle,
    output logic             comma_ins
);

    localparam int unsigned CNT_W  = $clog2(SYM_W);
    localparam int unsigned ACNT_W = (ALIGN_PERIOD > 32'd0) ? $clog2(ALIGN_PERIOD + 32'd1) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(SYM_W - 32'd1);
    localparam logic [ACNT_W-1:0] ACNT_MAX  = ACNT_W'(ALIGN_PERIOD);
    localparam bit                ALIGN_EN  = (ALIGN_PERIOD != 32'd0);

    function automatic logic lfsr_feedback(input logic [PRBS_LEN-1:0] state);
        return ^(state & PRBS_TAPS);
    endfunction

    // The register drains toward whichever end feeds the line.
    function automatic logic [SYM_W-1:0] shift_toward_line(input logic [SYM_W-1:0] sr);
        if (LSB_FIRST) begin
            return {1'b0, sr[SYM_W-1:1]};
        end else begin
            return {sr[SYM_W-2:0], 1'b0};
        end
    endfunction

    logic [SYM_W-1:0]    shreg_q,  shreg_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [ACNT_W-1:0]   acnt_q,   acnt_d;
    logic [PRBS_LEN-1:0] lfsr_q,   lfsr_d;
    logic                out_q,    out_d;
    logic                idle_q,   idle_d;
    logic                comma_q,  comma_d;

    logic                load_s;
    logic                force_comma_s;
    logic                line_bit_s;
    logic [ACNT_W-1:0]   acnt_inc_s;

    assign load_s        = (bitcnt_q == LAST_BIT);
    assign force_comma_s = ALIGN_EN && (acnt_q == ACNT_MAX);
    assign line_bit_s    = LSB_FIRST ? shreg_q[0] : shreg_q[SYM_W-1];
    assign acnt_inc_s    = ALIGN_EN ? (acnt_q + 1'b1) : '0;

    assign sym_ready = load_s && !force_comma_s && !prbs_on;
    assign out       = out_q;
    assign idle      = idle_q;
    assign comma_ins = comma_q;

    // Next-state selection for framing and PRBS modes.
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        acnt_d   = acnt_q;
        lfsr_d   = lfsr_q;
        out_d    = out_q;
        idle_d   = idle_q;
        comma_d  = 1'b0;
        if (prbs_on) begin
            // Framing is parked on a fresh idle symbol so it restarts cleanly on exit.
            out_d    = lfsr_q[0];
            lfsr_d   = {lfsr_q[PRBS_LEN-2:0], lfsr_feedback(lfsr_q)};
            bitcnt_d = '0;
            shreg_d  = IDLE_SYM;
            acnt_d   = '0;
            idle_d   = 1'b1;
        end else begin
            out_d   = line_bit_s;
            shreg_d = shift_toward_line(shreg_q);
            if (load_s) begin
                bitcnt_d = '0;
                if (force_comma_s) begin
                    shreg_d = IDLE_SYM;
                    acnt_d  = '0;
                    idle_d  = 1'b1;
                    comma_d = 1'b1;
                end else if (sym_valid) begin
                    shreg_d = sym_in;
                    acnt_d  = acnt_inc_s;
                    idle_d  = 1'b0;
                end else begin
                    shreg_d = IDLE_SYM;
                    acnt_d  = '0;
                    idle_d  = 1'b1;
                end
            end else begin
                bitcnt_d = bitcnt_q + 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_bit) begin
        if (rst) begin
            shreg_q  <= IDLE_SYM;
            bitcnt_q <= '0;
            acnt_q   <= '0;
            lfsr_q   <= PRBS_SEED;
            out_q    <= 1'b0;
            idle_q   <= 1'b1;
            comma_q  <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            acnt_q   <= acnt_d;
            lfsr_q   <= lfsr_d;
            out_q    <= out_d;
            idle_q   <= idle_d;
            comma_q  <= comma_d;
        end
    end

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: idle fill, data framing, forced commas, PRBS, reset.
module tb_tx_serializer;

    logic       clk_bit = 1'b0;
    logic       rst;
    logic [9:0] sym_in;
    logic       sym_valid;
    logic       prbs_on;
    logic       sym_ready, out, idle, comma_ins;
    logic       al_ready, al_out, al_idle, al_comma;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0]  idle_v = 10'h17C;
    logic [9:0]  d2aa   = 10'h2AA;
    logic [9:0]  d155   = 10'h155;
    logic [2:0]  prbs_first = 3'b100;
    logic [15:0] m;
    logic        exp_bit;

    always #5 clk_bit = ~clk_bit;

    tx_serializer dut (
        .clk_bit(clk_bit), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .prbs_on(prbs_on), .out(out), .idle(idle),
        .comma_ins(comma_ins)
    );

    tx_serializer #(.ALIGN_PERIOD(4)) dut_al (
        .clk_bit(clk_bit), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(al_ready), .prbs_on(prbs_on), .out(al_out), .idle(al_idle),
        .comma_ins(al_comma)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_bit);
        @(negedge clk_bit);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        sym_valid = 1'b0;
        sym_in    = 10'h000;
        prbs_on   = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check_value("rst_out",   {31'd0, out},       32'd0);
        check_value("rst_idle",  {31'd0, idle},      32'd1);
        check_value("rst_comma", {31'd0, comma_ins}, 32'd0);
        check_value("rst_ready", {31'd0, sym_ready}, 32'd0);

        // Idle fill: IDLE_SYM repeats LSB first, ready pulses at bitcnt 9.
        for (int k = 0; k < 30; k++) begin
            check_value($sformatf("idle_ready%0d", k), {31'd0, sym_ready}, {31'd0, (k % 10) == 9});
            step();
            check_value($sformatf("idle_out%0d", k), {31'd0, out}, {31'd0, idle_v[k % 10]});
            check_value($sformatf("idle_idle%0d", k), {31'd0, idle}, 32'd1);
        end

        // Data 2AA then 155 back to back.
        sym_valid = 1'b1;
        sym_in    = 10'h2AA;
        for (int j = 0; j < 10; j++) begin
            check_value($sformatf("d_wait_ready%0d", j), {31'd0, sym_ready}, {31'd0, j == 9});
            step();
        end
        check_value("d_idle_low", {31'd0, idle}, 32'd0);
        sym_in = 10'h155;
        for (int i = 0; i < 10; i++) begin
            check_value($sformatf("d1_ready%0d", i), {31'd0, sym_ready}, {31'd0, i == 9});
            step();
            check_value($sformatf("d1_out%0d", i), {31'd0, out}, {31'd0, d2aa[i]});
            check_value($sformatf("d1_idle%0d", i), {31'd0, idle}, 32'd0);
        end
        sym_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_value($sformatf("d2_out%0d", i), {31'd0, out}, {31'd0, d155[i]});
            check_value($sformatf("d2_idle%0d", i), {31'd0, idle}, {31'd0, i == 9});
        end

        // Forced alignment comma after 4 data symbols (dut_al), none on dut.
        do_reset();
        sym_valid = 1'b1;
        sym_in    = 10'h2AA;
        for (int n = 1; n <= 60; n++) begin
            check_value($sformatf("al_ready%0d", n), {31'd0, al_ready},
                        {31'd0, (n % 10 == 0) && (n != 50)});
            check_value($sformatf("nal_ready%0d", n), {31'd0, sym_ready}, {31'd0, n % 10 == 0});
            step();
            check_value($sformatf("al_comma%0d", n), {31'd0, al_comma}, {31'd0, n == 50});
            check_value($sformatf("nal_comma%0d", n), {31'd0, comma_ins}, 32'd0);
            check_value($sformatf("al_idle%0d", n), {31'd0, al_idle},
                        {31'd0, (n < 10) || (n >= 50 && n < 60)});
            if (n <= 10) exp_bit = idle_v[n - 1];
            else if (n >= 51) exp_bit = idle_v[n - 51];
            else exp_bit = d2aa[(n - 11) % 10];
            check_value($sformatf("al_out%0d", n), {31'd0, al_out}, {31'd0, exp_bit});
            if (n <= 10) exp_bit = idle_v[n - 1];
            else exp_bit = d2aa[(n - 11) % 10];
            check_value($sformatf("nal_out%0d", n), {31'd0, out}, {31'd0, exp_bit});
        end
        sym_valid = 1'b0;

        // PRBS straight after reset against a bench LFSR model.
        do_reset();
        prbs_on = 1'b1;
        m = 16'h5678;
        for (int i = 0; i < 40; i++) begin
            step();
            exp_bit = m[0];
            m = {m[14:0], ^(m & 16'hB400)};
            if (i < 3) check_value($sformatf("prbs_first%0d", i), {31'd0, out}, {31'd0, prbs_first[i]});
            check_value($sformatf("prbs_out%0d", i), {31'd0, out}, {31'd0, exp_bit});
            check_value($sformatf("prbs_ready%0d", i), {31'd0, sym_ready}, 32'd0);
            check_value($sformatf("prbs_idle%0d", i), {31'd0, idle}, 32'd1);
        end
        check_value("prbs_model_step2", {16'd0, m}, {16'd0, m});
        prbs_on = 1'b0;

        // PRBS mid-symbol for 7 cycles, then framing restarts on a full IDLE_SYM.
        do_reset();
        sym_valid = 1'b1;
        sym_in    = 10'h2AA;
        for (int i = 0; i < 4; i++) step();
        prbs_on = 1'b1;
        m = 16'h5678;
        for (int i = 0; i < 7; i++) begin
            step();
            check_value($sformatf("mid_prbs_out%0d", i), {31'd0, out}, {31'd0, m[0]});
            m = {m[14:0], ^(m & 16'hB400)};
        end
        prbs_on   = 1'b0;
        sym_valid = 1'b0;
        for (int j = 0; j < 10; j++) begin
            check_value($sformatf("exit_ready%0d", j), {31'd0, sym_ready}, {31'd0, j == 9});
            step();
            check_value($sformatf("exit_out%0d", j), {31'd0, out}, {31'd0, idle_v[j]});
            check_value($sformatf("exit_idle%0d", j), {31'd0, idle}, 32'd1);
        end

        // Reset in the middle of a data symbol.
        do_reset();
        sym_valid = 1'b1;
        sym_in    = 10'h155;
        for (int i = 0; i < 10; i++) step();
        sym_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_value("mid_data_idle", {31'd0, idle}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_value("mrst_out",   {31'd0, out},       32'd0);
        check_value("mrst_idle",  {31'd0, idle},      32'd1);
        check_value("mrst_ready", {31'd0, sym_ready}, 32'd0);
        for (int j = 0; j < 10; j++) begin
            step();
            check_value($sformatf("mrst_out%0d", j), {31'd0, out}, {31'd0, idle_v[j]});
            check_value($sformatf("mrst_idle%0d", j), {31'd0, idle}, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
